packed_framebuffer: RTL and testbench
=====================================

Name: packed_framebuffer

Overview:
- Parametrised packed-pixel framebuffer: the next generation of the byte-write URAM plus test-driver pair.
- Stores PIX_W-bit colour indices, LANES pixels per RAM word. Each pixel occupies one COL_W-bit byte lane and is updated with a per-lane write enable.
- Arbitrates one single-port read-first RAM between the PPU pixel-write stream (buffered, ready/valid) and the video scan-out read stream (always has priority, fixed latency).
- Adds a hardware frame-clear mode. Sits between the PPU pixel output and the video timing generator.

Parameters:
- H_ACTIVE, 256, visible pixels per line; must be a multiple of LANES.
- V_ACTIVE, 240, visible lines per frame.
- PIX_W, 6, colour index width; must be ≤ COL_W.
- COL_W, 8, byte-lane width in bits.
- LANES, 8, pixels per RAM word; must be a power of two.
- WFIFO_DEPTH, 4, write-buffer entries; must be a power of two, ≥ 2.
- CLEAR_COLOR, 6'h0F, colour written to every pixel by a clear.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wr_valid  in  1  pixel write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_x  in  9  pixel column
- wr_y  in  9  pixel row
- wr_color  in  PIX_W  pixel colour
- rd_req  in  1  scan-out read request; no backpressure
- rd_x  in  9  read column
- rd_y  in  9  read row
- rd_valid  out  1  read data valid
- rd_color  out  PIX_W  read colour
- clear_start  in  1  single-cycle pulse: start frame clear
- clear_busy  out  1  clear in progress

Behaviour:
- Addressing: p = y*H_ACTIVE + x. Word address = p >> log2(LANES); lane = p mod LANES. DEPTH = H_ACTIVE*V_ACTIVE/LANES (7680 at defaults).
- RAM: DEPTH × (LANES*COL_W), read-first, registered output, per-lane write enable. Contents are not reset. Lane data = zero-extended colour.
- Reset: rd_valid=0, rd_color=0, clear_busy=0, FIFO empty, state IDLE, read pipeline flushed. wr_ready reads 1 once rst deasserts.
- Read path, priority 1: a rd_req sampled at cycle N occupies the RAM port in cycle N. rd_valid/rd_color appear registered at cycle N+2 (RAM output register, then lane-select register).
  - Back-to-back requests give back-to-back results.
  - Out-of-range coordinates (x ≥ H_ACTIVE or y ≥ V_ACTIVE) do not touch RAM and return rd_color=0 with normal latency.
- Write path:
  - wr_ready = (state==IDLE) && FIFO not full && !clear_start (combinational).
  - Accepted writes enter the FIFO with the word address and lane already computed. Out-of-range writes are accepted and dropped (never enqueued).
  - FIFO head is written to RAM, with only its lane enabled, in any cycle where state==IDLE and rd_req==0.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - No read-after-write forwarding: a read issued while the target write is still queued returns the old value.
- State machine:
  - IDLE: clear_start → CLEAR. The FIFO is flushed (pending writes discarded), the clear address is set to 0, and clear_busy goes high the next cycle.
  - CLEAR: in each cycle with rd_req==0, write word clear_addr with all lanes = CLEAR_COLOR, then increment. Read cycles stall the clear. After writing word DEPTH-1, go to IDLE and drop clear_busy the next cycle.
  - clear_start while in CLEAR is ignored.
- Simultaneous events:
  - clear_start with wr_valid in IDLE: clear wins and the write is not accepted.
  - rd_req during a FIFO pop or clear write: the read takes the port and the write waits.
- Reset mid-operation: immediate return to IDLE, FIFO emptied, in-flight reads dropped (rd_valid=0). RAM is left partially written.
- Starvation: continuous rd_req blocks writes indefinitely. wr_ready falls when the FIFO reaches WFIFO_DEPTH entries.

Test Plan:
- Write (10,20)=0x2A, idle 2 cycles, rd_req (10,20) → rd_valid exactly 2 cycles later with rd_color=0x2A. Adjacent lanes (9,20) and (11,20) keep prior values.
- Write all 8 lanes of word 0 with colours 1..8, then read x=0..7 on consecutive cycles → eight consecutive rd_valid beats with 1..8.
- Hold rd_req high 20 cycles while writing 6 pixels → wr_ready low after 4 accepted. After rd_req drops, the FIFO drains in 4 cycles and all 6 pixels read back correctly.
- clear_start with no reads → clear_busy high for exactly 7680 cycles, then every sampled pixel (0,0), (255,239) and (128,100) reads 0x0F. A write offered on the clear_start cycle is not accepted.
- Write (300,5) and read (300,5) → write dropped, wr_ready stays 1, read returns 0 with rd_valid at latency 2, RAM unchanged.
- Assert rst 100 cycles into a clear with a read in flight → clear_busy=0 and rd_valid=0 immediately. After release wr_ready=1, and words ≥ the interrupted address retain old data.

Source files
------------

// File: rtl/packed_framebuffer_if.sv
// Pixel-write, scan-out read and frame-clear signals of the packed framebuffer.
// The master drives requests and the slave (the framebuffer) answers them.
interface packed_framebuffer_if #(
  parameter int unsigned PIX_W = 6
);
  logic             wr_valid;
  logic             wr_ready;
  logic [8:0]       wr_x;
  logic [8:0]       wr_y;
  logic [PIX_W-1:0] wr_color;
  logic             rd_req;
  logic [8:0]       rd_x;
  logic [8:0]       rd_y;
  logic             rd_valid;
  logic [PIX_W-1:0] rd_color;
  logic             clear_start;
  logic             clear_busy;

  modport master (
    output wr_valid, wr_x, wr_y, wr_color, rd_req, rd_x, rd_y, clear_start,
    input  wr_ready, rd_valid, rd_color, clear_busy
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_color, rd_req, rd_x, rd_y, clear_start,
    output wr_ready, rd_valid, rd_color, clear_busy
  );
endinterface

// File: rtl/packed_framebuffer.sv
// Packed-pixel framebuffer: one single-port read-first RAM shared by a buffered
// pixel-write stream, a priority scan-out read stream and a hardware frame clear.
module packed_framebuffer #(
  parameter int unsigned H_ACTIVE    = 256,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned PIX_W       = 6,
  parameter int unsigned COL_W       = 8,
  parameter int unsigned LANES       = 8,
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = PIX_W'(15)
) (
  input  logic clk,
  input  logic rst,
  packed_framebuffer_if.slave bus
);

  localparam int unsigned DEPTH = H_ACTIVE * V_ACTIVE / LANES;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = $clog2(LANES);
  localparam int unsigned PW    = $clog2(H_ACTIVE * V_ACTIVE);
  localparam int unsigned FW    = $clog2(WFIFO_DEPTH);
  localparam int unsigned CW    = FW + 1;
  localparam int unsigned WW    = LANES * COL_W;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [LW-1:0]    lane;
    logic [PIX_W-1:0] color;
  } wr_entry_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic logic in_range(input logic [8:0] x, input logic [8:0] y);
    return (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);
  endfunction

  function automatic logic [PW-1:0] pix_index(input logic [8:0] x, input logic [8:0] y);
    logic [31:0] t;
    t = 32'(y) * H_ACTIVE + 32'(x);
    return PW'(t);
  endfunction

  state_t           state;
  logic             clear_busy_q;
  logic [AW-1:0]    clear_addr;
  wr_entry_t        fifo_mem [WFIFO_DEPTH];
  logic [FW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic [WW-1:0]    mem [DEPTH];
  logic [WW-1:0]    ram_q;
  logic             rd_v1, rd_ok1;
  logic [LW-1:0]    rd_lane1;
  logic             rd_valid_q;
  logic [PIX_W-1:0] rd_color_q;

  logic [PW-1:0]    wr_p, rd_p;
  logic             wr_ok, rd_ok, fifo_full, fifo_empty;
  logic             push, pop, clr_we, rd_go;
  wr_entry_t        head;
  logic [LANES-1:0] ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [WW-1:0]    ram_wdata;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_sel;

  assign wr_p       = pix_index(bus.wr_x, bus.wr_y);
  assign rd_p       = pix_index(bus.rd_x, bus.rd_y);
  assign wr_ok      = in_range(bus.wr_x, bus.wr_y);
  assign rd_ok      = in_range(bus.rd_x, bus.rd_y);
  assign rd_addr    = AW'(rd_p >> LW);
  assign fifo_full  = (count == CW'(WFIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rptr];

  // Reads always own the port; writes and clear steps only use idle port cycles.
  assign bus.wr_ready = (state == IDLE) && !fifo_full && !bus.clear_start;
  assign push   = bus.wr_valid && bus.wr_ready && wr_ok;
  assign pop    = (state == IDLE) && !bus.rd_req && !fifo_empty && !bus.clear_start;
  assign clr_we = (state == CLEAR) && !bus.rd_req;
  assign rd_go  = bus.rd_req && rd_ok;

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_color   = rd_color_q;
  assign bus.clear_busy = clear_busy_q;

  // RAM write port: either a whole-word clear or a single-lane pixel update.
  always_comb begin
    ram_we    = '0;
    ram_waddr = head.addr;
    ram_wdata = {LANES{COL_W'(head.color)}};
    if (clr_we) begin
      ram_we    = '1;
      ram_waddr = clear_addr;
      ram_wdata = {LANES{COL_W'(CLEAR_COLOR)}};
    end else if (pop) begin
      ram_we[head.lane] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_go) ram_q <= mem[rd_addr];
    for (int i = 0; i < LANES; i++) begin
      if (ram_we[i]) mem[ram_waddr][i*COL_W +: COL_W] <= ram_wdata[i*COL_W +: COL_W];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= '{addr: AW'(wr_p >> LW), lane: wr_p[LW-1:0], color: bus.wr_color};
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rd_lane1 == LW'(i)) rd_sel = ram_q[i*COL_W +: PIX_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      clear_busy_q <= 1'b0;
      clear_addr   <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      rd_v1        <= 1'b0;
      rd_ok1       <= 1'b0;
      rd_lane1     <= '0;
      rd_valid_q   <= 1'b0;
      rd_color_q   <= '0;
    end else begin
      // Two-stage read pipeline: RAM output register, then lane select.
      rd_v1      <= bus.rd_req;
      rd_ok1     <= rd_ok;
      rd_lane1   <= rd_p[LW-1:0];
      rd_valid_q <= rd_v1;
      rd_color_q <= (rd_v1 && rd_ok1) ? rd_sel : '0;

      case (state)
        IDLE: begin
          if (bus.clear_start) begin
            state        <= CLEAR;
            clear_busy_q <= 1'b1;
            clear_addr   <= '0;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
          end else begin
            if (push) wptr <= wptr + FW'(1);
            if (pop)  rptr <= rptr + FW'(1);
            case ({push, pop})
              2'b10:   count <= count + CW'(1);
              2'b01:   count <= count - CW'(1);
              default: count <= count;
            endcase
          end
        end
        CLEAR: begin
          if (clr_we) begin
            clear_addr <= clear_addr + AW'(1);
            if (clear_addr == AW'(DEPTH - 1)) begin
              state        <= IDLE;
              clear_busy_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packed_framebuffer.sv
// Self-checking bench for packed_framebuffer: a pixel-array/queue model checked
// every cycle, plus directed scenarios with literal expected colours.
module tb_packed_framebuffer;

  localparam int H     = 256;
  localparam int V     = 240;
  localparam int DEPTH = 7680;
  localparam logic [5:0] CC = 6'h0F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packed_framebuffer_if #(.PIX_W(6)) bus ();
  packed_framebuffer dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: pixel array, write queue, clear progress, read latency line.
  logic [5:0] m_mem [H*V];
  int         q_p [$];
  logic [5:0] q_c [$];
  bit         m_busy = 1'b0;
  int         m_clr  = 0;
  bit         s1_v = 1'b0, s2_v = 1'b0;
  logic [5:0] s1_c = '0, s2_c = '0;

  function automatic bit inr(input int x, input int y);
    return (x < H) && (y < V);
  endfunction

  function automatic bit m_ready();
    return !m_busy && (q_p.size() < 4) && !bus.clear_start;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit rdy;
    int rx, ry, wx, wy;
    if (rst) begin
      q_p.delete(); q_c.delete();
      m_busy = 1'b0; m_clr = 0;
      s1_v = 1'b0; s2_v = 1'b0; s1_c = '0; s2_c = '0;
    end else begin
      rdy = m_ready();
      rx = int'(bus.rd_x); ry = int'(bus.rd_y);
      wx = int'(bus.wr_x); wy = int'(bus.wr_y);
      s2_v = s1_v; s2_c = s1_c;
      s1_v = bus.rd_req;
      s1_c = (bus.rd_req && inr(rx, ry)) ? m_mem[ry*H + rx] : 6'h00;
      if (m_busy) begin
        if (!bus.rd_req) begin
          for (int l = 0; l < 8; l++) m_mem[m_clr*8 + l] = CC;
          m_clr++;
          if (m_clr == DEPTH) m_busy = 1'b0;
        end
      end else if (bus.clear_start) begin
        m_busy = 1'b1; m_clr = 0;
        q_p.delete(); q_c.delete();
      end else begin
        if (!bus.rd_req && q_p.size() > 0) m_mem[q_p.pop_front()] = q_c.pop_front();
        if (bus.wr_valid && rdy && inr(wx, wy)) begin
          q_p.push_back(wy*H + wx);
          q_c.push_back(bus.wr_color);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("rd_valid", bus.rd_valid, s2_v);
    if (s2_v) check("rd_color", bus.rd_color, s2_c);
    check("clear_busy", bus.clear_busy, m_busy);
    check("wr_ready", bus.wr_ready, m_ready());
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr_pix(input int x, input int y, input logic [5:0] c);
    bus.wr_valid = 1'b1; bus.wr_x = 9'(x); bus.wr_y = 9'(y); bus.wr_color = c;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.wr_ready) begin
        step();
        bus.wr_valid = 1'b0;
        return;
      end
      step();
    end
    check("wr_timeout", 0, 1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic expect_pix(input string name, input int x, input int y, input logic [5:0] exp);
    bus.rd_req = 1'b1; bus.rd_x = 9'(x); bus.rd_y = 9'(y);
    step();
    bus.rd_req = 1'b0;
    check({name, "_lat1"}, bus.rd_valid, 0);
    step();
    check({name, "_valid"}, bus.rd_valid, 1);
    check(name, bus.rd_color, exp);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, acc;
    bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_color = '0;
    bus.rd_req = 1'b0; bus.rd_x = '0; bus.rd_y = '0; bus.clear_start = 1'b0;
    idle(3);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_color", bus.rd_color, 0);
    check("rst_clear_busy", bus.clear_busy, 0);
    rst = 1'b0;
    step();
    check("rst_wr_ready", bus.wr_ready, 1);

    // Full clear; a write offered on the clear_start cycle must be refused.
    bus.clear_start = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_x = 9'd10; bus.wr_y = 9'd10; bus.wr_color = 6'h01;
    @(negedge clk);
    check("clr_wr_ready", bus.wr_ready, 0);
    step();
    bus.clear_start = 1'b0; bus.wr_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 8000; i++) begin
      if (!bus.clear_busy) break;
      n++;
      step();
    end
    check("clear_cycles", n, DEPTH);
    expect_pix("clr_0_0", 0, 0, CC);
    expect_pix("clr_255_239", 255, 239, CC);
    expect_pix("clr_128_100", 128, 100, CC);
    expect_pix("clr_10_10", 10, 10, CC);

    // Single-lane write leaves neighbouring lanes alone.
    wr_pix(10, 20, 6'h2A);
    idle(2);
    expect_pix("px_10_20", 10, 20, 6'h2A);
    expect_pix("px_9_20", 9, 20, CC);
    expect_pix("px_11_20", 11, 20, CC);

    // All lanes of word 0, then eight back-to-back reads.
    for (int i = 0; i < 8; i++) wr_pix(i, 0, 6'(i + 1));
    idle(2);
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        check("burst_valid", bus.rd_valid, 1);
        check("burst_color", bus.rd_color, k - 1);
      end
      bus.rd_req = (k < 8); bus.rd_x = 9'(k); bus.rd_y = 9'd0;
      step();
    end
    bus.rd_req = 1'b0;

    // Continuous reads starve the write queue until it fills.
    bus.rd_req = 1'b1; bus.rd_x = 9'd0; bus.rd_y = 9'd0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      bus.wr_valid = (acc < 6);
      bus.wr_x = 9'(16 + acc); bus.wr_y = 9'd3; bus.wr_color = 6'(16 + acc);
      @(negedge clk);
      if (bus.wr_valid && bus.wr_ready) acc++;
      step();
    end
    check("starve_accepted", acc, 4);
    @(negedge clk);
    check("starve_wr_ready", bus.wr_ready, 0);
    step();
    bus.rd_req = 1'b0; bus.wr_valid = 1'b0;
    step();
    check("drain_wr_ready", bus.wr_ready, 1);
    idle(4);
    for (int j = acc; j < 6; j++) wr_pix(16 + j, 3, 6'(16 + j));
    idle(2);
    for (int j = 0; j < 6; j++) expect_pix("starve_px", 16 + j, 3, 6'(16 + j));

    // Out-of-range write is accepted and dropped; out-of-range read returns 0.
    bus.wr_valid = 1'b1; bus.wr_x = 9'd300; bus.wr_y = 9'd5; bus.wr_color = 6'h3F;
    @(negedge clk);
    check("oor_wr_ready", bus.wr_ready, 1);
    step();
    bus.wr_valid = 1'b0;
    idle(2);
    expect_pix("oor_rd", 300, 5, 6'h00);
    expect_pix("oor_alias", 44, 6, CC);

    // Reset part-way through a clear with a read in flight.
    wr_pix(200, 200, 6'h33);
    wr_pix(8, 0, 6'h07);
    idle(2);
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    idle(98);
    bus.rd_req = 1'b1; bus.rd_x = 9'd200; bus.rd_y = 9'd200;
    step();
    bus.rd_req = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_clear_busy", bus.clear_busy, 0);
    check("mid_rst_rd_valid", bus.rd_valid, 0);
    idle(2);
    rst = 1'b0;
    step();
    check("post_rst_wr_ready", bus.wr_ready, 1);
    expect_pix("kept_200_200", 200, 200, 6'h33);
    expect_pix("cleared_8_0", 8, 0, CC);
    expect_pix("cleared_0_0", 0, 0, CC);

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
